// File: rtl/sonar_ranger.sv
`timescale 1ns/1ps
// sonar_ranger
//   Drives an HC-SR04-style ultrasonic sonar. It issues periodic trigger
//   pulses and times the echo pulse in clk cycles. The last result is held
//   stable so the SPI readout mux can sample it at any time. The result is a
//   raw cycle count; the RPi converts it to a distance.
//
// Parameters
//   TRIG_CYCLES     trigger high time in clk cycles
//   PERIOD_CYCLES   trigger-to-trigger period; must exceed TRIG_CYCLES+TIMEOUT_CYCLES
//   TIMEOUT_CYCLES  max cycles from trigger fall to echo fall before giving up
//   SYNC_STAGES     flops in the echo_in synchroniser (>= 2)
//
// Ports
//   clk          in   system clock
//   reset        in   asynchronous, active-low reset
//   enable       in   1 = run periodic measurements; 0 = stop after current cycle
//   echo_in      in   raw sonar ECHO pin (asynchronous)
//   trigger_out  out  sonar TRIGGER pin
//   echo_cycles  out  last echo high time in clk cycles; 32'hFFFF_FFFF = timeout
//   meas_valid   out  1-cycle pulse when echo_cycles/timed_out update
//   timed_out    out  1 = last completed cycle timed out
//   meas_count   out  number of completed cycles, wraps at 16 bits
//   busy         out  1 in any state other than IDLE
module sonar_ranger #(
  parameter int TRIG_CYCLES    = 500,
  parameter int PERIOD_CYCLES  = 3_000_000,
  parameter int TIMEOUT_CYCLES = 1_500_000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        echo_in,
  output logic        trigger_out,
  output logic [31:0] echo_cycles,
  output logic        meas_valid,
  output logic        timed_out,
  output logic [15:0] meas_count,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_ECHO = 3'd2,
    MEASURE   = 3'd3,
    DONE      = 3'd4,
    HOLDOFF   = 3'd5
  } state_t;

  localparam logic [31:0] TRIG_LAST    = 32'(TRIG_CYCLES - 1);
  localparam logic [31:0] PERIOD_LAST  = 32'(PERIOD_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] WIDTH_MAX    = 32'hFFFF_FFFE;
  localparam logic [31:0] TIMEOUT_CODE = 32'hFFFF_FFFF;

  state_t state;
  state_t next_state;

  logic [SYNC_STAGES-1:0] echo_sync_q;
  logic                   echo_sync;
  logic                   echo_prev;
  logic                   echo_rise;
  logic                   echo_fall;

  logic [31:0] trig_cnt;
  logic [31:0] period_cnt;
  logic [31:0] timeout_cnt;
  logic [31:0] width_cnt;

  logic timeout_hit;
  logic start_meas;
  logic report_ok;
  logic report_timeout;

  // Echo synchroniser plus one extra registered copy for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      echo_sync_q <= '0;
      echo_prev   <= 1'b0;
    end else begin
      echo_sync_q <= {echo_sync_q[SYNC_STAGES-2:0], echo_in};
      echo_prev   <= echo_sync;
    end
  end

  assign echo_sync = echo_sync_q[SYNC_STAGES-1];
  assign echo_rise = echo_sync & ~echo_prev;
  assign echo_fall = ~echo_sync & echo_prev;

  // timeout_cnt is 0 in the first WAIT_ECHO cycle, so the last allowed cycle
  // is TIMEOUT_CYCLES-1; the transition out lands exactly TIMEOUT_CYCLES
  // clocks after the trigger fell.
  assign timeout_hit = (timeout_cnt == TIMEOUT_LAST);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. Timeout is checked before edges so it wins a tie.
  always_comb begin
    next_state     = state;
    start_meas     = 1'b0;
    report_ok      = 1'b0;
    report_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          next_state = TRIG;
        end
      end
      TRIG: begin
        if (trig_cnt == TRIG_LAST) begin
          next_state = WAIT_ECHO;
        end
      end
      WAIT_ECHO: begin
        if (timeout_hit) begin
          next_state     = HOLDOFF;
          report_timeout = 1'b1;
        end else if (echo_rise) begin
          next_state = MEASURE;
          start_meas = 1'b1;
        end
      end
      MEASURE: begin
        if (timeout_hit) begin
          next_state     = HOLDOFF;
          report_timeout = 1'b1;
        end else if (echo_fall) begin
          next_state = DONE;
          report_ok  = 1'b1;
        end
      end
      DONE: begin
        next_state = HOLDOFF;
      end
      HOLDOFF: begin
        if (period_cnt == PERIOD_LAST) begin
          next_state = enable ? TRIG : IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Phase counters. The period counter is cleared on TRIG entry so the next
  // trigger rises exactly PERIOD_CYCLES clocks after the previous one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trig_cnt    <= '0;
      period_cnt  <= '0;
      timeout_cnt <= '0;
      width_cnt   <= '0;
    end else begin
      if (state == TRIG) begin
        trig_cnt <= trig_cnt + 32'd1;
      end else begin
        trig_cnt <= '0;
      end

      if (state != TRIG && next_state == TRIG) begin
        period_cnt <= '0;
      end else if (state != IDLE) begin
        period_cnt <= period_cnt + 32'd1;
      end

      if (state == TRIG) begin
        timeout_cnt <= '0;
      end else if (state == WAIT_ECHO || state == MEASURE) begin
        timeout_cnt <= timeout_cnt + 32'd1;
      end

      // The rising-edge cycle counts as the first high cycle.
      if (start_meas) begin
        width_cnt <= 32'd1;
      end else if (state == MEASURE && echo_sync && width_cnt != WIDTH_MAX) begin
        width_cnt <= width_cnt + 32'd1;
      end
    end
  end

  // Result registers. They change only together with the meas_valid pulse,
  // so the SPI side can sample them asynchronously. The measurement result is
  // loaded on entry to DONE, which makes DONE the meas_valid cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trigger_out <= 1'b0;
      meas_valid  <= 1'b0;
      echo_cycles <= '0;
      timed_out   <= 1'b0;
      meas_count  <= '0;
    end else begin
      trigger_out <= (next_state == TRIG);
      meas_valid  <= report_ok | report_timeout;
      if (report_ok) begin
        echo_cycles <= width_cnt;
        timed_out   <= 1'b0;
        meas_count  <= meas_count + 16'd1;
      end else if (report_timeout) begin
        echo_cycles <= TIMEOUT_CODE;
        timed_out   <= 1'b1;
        meas_count  <= meas_count + 16'd1;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
